// File: rtl/handshake_fifo_buffer.sv
// Valid/ready FIFO buffer: NUM_SLOTS-entry circular storage with registered
// handshake flags, so neither ready nor valid depends combinationally on the other side.
module handshake_fifo_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLOTS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam int PTR_W = $clog2(NUM_SLOTS);
  localparam int CNT_W = $clog2(NUM_SLOTS + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_SLOTS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SLOTS);

  logic [DATA_WIDTH-1:0] mem_q [NUM_SLOTS];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push, pop;

  // Flags come from count_q alone: a pop cannot free a slot for a push in the same cycle.
  assign ins_ready  = (count_q != FULL_CNT);
  assign outs_valid = (count_q != '0);
  assign outs       = mem_q[head_q];

  assign push = ins_valid && ins_ready;
  assign pop  = outs_valid && outs_ready;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      head_d = (head_q == LAST_PTR) ? '0 : head_q + PTR_W'(1);
    end
    if (push) begin
      tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage has no reset; stale entries are unreachable once count_q is cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= ins;
    end
  end

endmodule
